bcd_conv_arbiter: RTL and testbench
===================================

Name: bcd_conv_arbiter

Overview:
Shares one multi-cycle BCD-to-binary converter between NUM_REQ requesters using round-robin arbitration.
- Accepts a 10-digit packed-BCD operand from the granted requester and validates its digits.
- Sequences the converter through a start/done handshake and returns the 32-bit binary result, or an error, to that requester.
- Sits between requester logic (display/UART front-ends) and the single shared converter instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DIGITS, 10, BCD digits per operand; BCD_W = 4*DIGITS
BIN_W, 32, binary result width
TIMEOUT_CYC, 64, converter watchdog limit in cycles (used only with the optional feature)

Ports:
clk_i  in  1  system clock, rising edge
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  NUM_REQ  per-requester operand valid, held until accepted
req_bcd_i  in  NUM_REQ x BCD_W  per-requester packed BCD operand, digit 0 in bits [3:0]
req_ready_o  out  NUM_REQ  one-hot, one-cycle accept pulse
rsp_valid_o  out  NUM_REQ  one-hot, one-cycle response pulse; no backpressure
rsp_binary_o  out  BIN_W  result, valid when any rsp_valid_o bit is set
rsp_error_o  out  1  qualifies the response: 1 = invalid digit or timeout, rsp_binary_o = 0
conv_start_o  out  1  one-cycle start pulse to the converter
conv_bcd_o  out  BCD_W  operand to the converter, stable from START until the response
conv_done_i  in  1  converter completion pulse
conv_binary_i  in  BIN_W  converter result, sampled when conv_done_i = 1
busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE, rr pointer = 0.
- All outputs 0 while reset is asserted, including conv_bcd_o and rsp_binary_o.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - If any req_valid_i is high, grant the first valid index at or after ptr, wrapping modulo NUM_REQ.
  - Assert req_ready_o[g] this cycle, latch req_bcd_i[g] into conv_bcd_o, latch g, and set ptr = g+1 (wrap).
  - If any latched nibble > 9, set the error flag and go to RESP; otherwise go to START.
  - A requester with no valid request never blocks the others.
- START: conv_start_o = 1 for exactly one cycle, then WAIT.
- WAIT:
  - Stay until conv_done_i = 1, then capture conv_binary_i and go to RESP.
  - conv_done_i is ignored in every other state.
- RESP:
  - rsp_valid_o[g] = 1 for one cycle, with rsp_binary_o and rsp_error_o valid.
  - Next state is IDLE; a new grant can occur in the cycle after RESP.
- Latency: accept at cycle 0, start at 1, earliest done at 2, response at 3. Invalid-digit responses arrive at cycle 1.
- rsp_binary_o and rsp_error_o hold their last values outside RESP; consumers qualify them with rsp_valid_o.
- Requests arriving while busy_o = 1 wait; req_valid_i must stay asserted until accepted.
- Simultaneous requests from all NUM_REQ requesters are served in strict rotation, so there is no starvation.
- Reset mid-conversion:
  - Abandons the transaction with no response.
  - The converter must itself be reset by the same rst_ni.

Optional Feature:
BCD_CONV_TIMEOUT_EN
- Defined:
  - A cycle counter runs in WAIT.
  - If conv_done_i has not arrived after TIMEOUT_CYC cycles in WAIT, go to RESP with rsp_error_o = 1 and rsp_binary_o = 0.
  - A conv_done_i that arrives late is ignored.
- Not defined: no counter is built and WAIT lasts until conv_done_i.

Decomposition:
- Package bcd_conv_pkg contains:
  - state_t enum (IDLE, START, WAIT, RESP)
  - BCD_W and BIN_W localparams
  - the digit_valid function (nibble <= 9)
- Sub-module rr_arbiter: combinational NUM_REQ-wide grant from (valid, ptr), giving a one-hot grant and a grant index.

Test Plan:
- Single valid request: req 0, BCD 0x00001010; converter model returns 0x3F2 after 3 cycles → rsp_valid_o = 0001, rsp_binary_o = 0x3F2, rsp_error_o = 0.
- Invalid digit: req 1, BCD 0x0000001A → no conv_start_o pulse; rsp_valid_o = 0010 one cycle after the accept, rsp_error_o = 1, rsp_binary_o = 0.
- All four requesters valid at once with ptr = 0 → grants in order 0, 1, 2, 3. A second round begun after requester 3 is served starts at 0.
- Maximum operand: BCD 0x4294967295 → 0xFFFFFFFF; done in the same cycle as start is ignored, and conversion completes on the next done pulse.
- rst_ni pulsed low while in WAIT → all outputs go to 0 immediately, no rsp_valid_o pulse, and the next request is granted from ptr 0.
- With BCD_CONV_TIMEOUT_EN and TIMEOUT_CYC = 64, converter never asserts done → error response 64 cycles after entering WAIT.

Source files
------------

// File: rtl/bcd_conv_pkg.sv
// Shared types and helpers for the round-robin BCD converter arbiter.
// Optional watchdog in the top: BCD_CONV_TIMEOUT_EN.
package bcd_conv_pkg;

  localparam int DIGITS = 10;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int BIN_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_t;

  function automatic logic digit_valid(
    input logic [3:0] nib
  );
    return nib <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_conv_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first valid index at or after ptr.
// Produces a one-hot grant plus the binary grant index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int k;
    logic [PW-1:0] ki;
    logic found;
    k     = 0;
    ki    = '0;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr_i) + i;
      if (k >= N) k = k - N;
      ki = PW'(k);
      if (!found && valid_i[ki]) begin
        found     = 1'b1;
        gnt_o[ki] = 1'b1;
        idx_o     = ki;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one BCD-to-binary converter between NUM_REQ requesters.
// Define BCD_CONV_TIMEOUT_EN to add a WAIT-state watchdog.
module bcd_conv_arbiter
  import bcd_conv_pkg::*;
#(
  parameter int NUM_REQ = 4
`ifdef BCD_CONV_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ-1:0][BCD_W-1:0]   req_bcd_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output logic [NUM_REQ-1:0]              rsp_valid_o,
  output logic [BIN_W-1:0]                rsp_binary_o,
  output logic                            rsp_error_o,
  output logic                            conv_start_o,
  output logic [BCD_W-1:0]                conv_bcd_o,
  input  logic                            conv_done_i,
  input  logic [BIN_W-1:0]                conv_binary_i,
  output logic                            busy_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               state_q;
  logic [PW-1:0]        ptr_q;
  logic [PW-1:0]        ptr_d;
  logic [PW-1:0]        gidx_q;
  logic [PW-1:0]        gidx;
  logic [NUM_REQ-1:0]   gnt;
  logic                 any_req;
  logic                 conv_start_q;
  logic [BCD_W-1:0]     conv_bcd_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [BIN_W-1:0]     rsp_binary_q;
  logic                 rsp_error_q;
  logic [BCD_W-1:0]     sel_bcd;
  logic                 sel_ok;

`ifdef BCD_CONV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q;
`endif

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .idx_o   (gidx),
    .any_o   (any_req)
  );

  always_comb begin
    sel_bcd = req_bcd_i[gidx];
    sel_ok  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!digit_valid(sel_bcd[4*i +: 4])) sel_ok = 1'b0;
    end
  end

  always_comb begin
    if (gidx == PW'(NUM_REQ - 1)) ptr_d = '0;
    else                          ptr_d = gidx + PW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      gidx_q       <= '0;
      conv_start_q <= 1'b0;
      conv_bcd_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_binary_q <= '0;
      rsp_error_q  <= 1'b0;
`ifdef BCD_CONV_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      conv_start_q <= 1'b0;
      rsp_valid_q  <= '0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            conv_bcd_q <= sel_bcd;
            gidx_q     <= gidx;
            ptr_q      <= ptr_d;
            if (sel_ok) begin
              state_q      <= START;
              conv_start_q <= 1'b1;
            end else begin
              state_q      <= RESP;
              rsp_valid_q  <= gnt;
              rsp_error_q  <= 1'b1;
              rsp_binary_q <= '0;
            end
          end
        end
        START: begin
          state_q <= WAIT;
`ifdef BCD_CONV_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        WAIT: begin
          if (conv_done_i) begin
            state_q      <= RESP;
            rsp_valid_q  <= NUM_REQ'(1) << gidx_q;
            rsp_error_q  <= 1'b0;
            rsp_binary_q <= conv_binary_i;
          end
`ifdef BCD_CONV_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_q      <= RESP;
            rsp_valid_q  <= NUM_REQ'(1) << gidx_q;
            rsp_error_q  <= 1'b1;
            rsp_binary_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Accept is combinational so the grant lands in the sampling cycle.
  assign req_ready_o  = (rst_ni && state_q == IDLE) ? gnt : '0;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_binary_o = rsp_binary_q;
  assign rsp_error_o  = rsp_error_q;
  assign conv_start_o = conv_start_q;
  assign conv_bcd_o   = conv_bcd_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Randomised and directed bench for bcd_conv_arbiter against a
// decimal-arithmetic reference model with a rotating-priority scheduler.
module tb_bcd_conv_arbiter;
  import bcd_conv_pkg::*;

  localparam int N = 4;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [N-1:0]             req_valid;
  logic [N-1:0][BCD_W-1:0]  req_bcd;
  logic [N-1:0]             req_ready;
  logic [N-1:0]             rsp_valid;
  logic [BIN_W-1:0]         rsp_binary;
  logic                     rsp_error;
  logic                     conv_start;
  logic [BCD_W-1:0]         conv_bcd;
  logic                     conv_done;
  logic [BIN_W-1:0]         conv_bin;
  logic                     busy;

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;

  bcd_conv_arbiter #(.NUM_REQ(N)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (req_valid),
    .req_bcd_i     (req_bcd),
    .req_ready_o   (req_ready),
    .rsp_valid_o   (rsp_valid),
    .rsp_binary_o  (rsp_binary),
    .rsp_error_o   (rsp_error),
    .conv_start_o  (conv_start),
    .conv_bcd_o    (conv_bcd),
    .conv_done_i   (conv_done),
    .conv_binary_i (conv_bin),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint bcd_value(input logic [BCD_W-1:0] b);
    longint v;
    longint p;
    v = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      v = v + longint'(b[4*i +: 4]) * p;
      p = p * 10;
    end
    return v;
  endfunction

  function automatic bit bcd_ok(input logic [BCD_W-1:0] b);
    for (int i = 0; i < DIGITS; i++)
      if (b[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [BCD_W-1:0] rand_bcd(input bit bad);
    logic [BCD_W-1:0] b;
    int p;
    b = '0;
    for (int i = 0; i < DIGITS; i++)
      b[4*i +: 4] = 4'($urandom_range(9, 0));
    b[BCD_W-1 -: 4] = 4'($urandom_range(3, 0));
    if (bad) begin
      p = $urandom_range(DIGITS - 1, 0);
      b[4*p +: 4] = 4'($urandom_range(15, 10));
    end
    return b;
  endfunction

  // Entered at a negedge with the DUT idle and at least one request up.
  task automatic serve(input int dly, input bit early);
    int               k;
    logic [1:0]       g;
    bit               found;
    logic [N-1:0]     oh;
    logic [BCD_W-1:0] b;
    bit               ok;
    logic [BIN_W-1:0] exp;
    #1;
    g = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = (ptr_m + i) % N;
      if (!found && req_valid[2'(k)]) begin
        found = 1'b1;
        g = 2'(k);
      end
    end
    if (!found) return;
    oh = '0;
    oh[g] = 1'b1;
    chk("grant", 64'(req_ready), 64'(oh));
    b   = req_bcd[g];
    ok  = bcd_ok(b);
    exp = ok ? 32'(bcd_value(b)) : 32'd0;
    ptr_m = (int'(g) + 1) % N;
    @(negedge clk);
    req_valid[g] = 1'b0;
    req_bcd[g]   = 40'({$urandom(), $urandom()});
    if (!ok) begin
      chk("bad_nostart", 64'(conv_start), 64'd0);
      chk("bad_rsp", 64'(rsp_valid), 64'(oh));
      chk("bad_err", 64'(rsp_error), 64'd1);
      chk("bad_bin", 64'(rsp_binary), 64'd0);
    end else begin
      chk("start", 64'(conv_start), 64'd1);
      chk("conv_bcd", 64'(conv_bcd), 64'(b));
      chk("start_norsp", 64'(rsp_valid), 64'd0);
      if (early) begin
        conv_done = 1'b1;
        conv_bin  = 32'hDEADBEEF;
      end
      for (int d = 0; d < dly; d++) begin
        @(negedge clk);
        conv_done = 1'b0;
        conv_bin  = $urandom;
        chk("wait_busy", 64'(busy), 64'd1);
        chk("wait_norsp", 64'(rsp_valid), 64'd0);
      end
      @(negedge clk);
      chk("pre_done_norsp", 64'(rsp_valid), 64'd0);
      conv_done = 1'b1;
      conv_bin  = exp;
      @(negedge clk);
      conv_done = 1'b0;
      conv_bin  = $urandom;
      chk("rsp", 64'(rsp_valid), 64'(oh));
      chk("rsp_bin", 64'(rsp_binary), 64'(exp));
      chk("rsp_err", 64'(rsp_error), 64'd0);
      chk("bcd_stable", 64'(conv_bcd), 64'(b));
    end
    @(negedge clk);
    chk("rsp_pulse", 64'(rsp_valid), 64'd0);
    chk("idle", 64'(busy), 64'd0);
    chk("bin_hold", 64'(rsp_binary), 64'(exp));
  endtask

  initial begin
    logic [N-1:0] mask;
    int guard;
    conv_done = 1'b0;
    conv_bin  = $urandom;
    req_valid = '1;
    for (int i = 0; i < N; i++) req_bcd[2'(i)] = rand_bcd(1'b0);

    #2;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_start", 64'(conv_start), 64'd0);
    chk("rst_rsp", 64'(rsp_valid), 64'd0);
    chk("rst_bcd", 64'(conv_bcd), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Two full rounds with everybody requesting.
    for (int r = 0; r < 2; r++) begin
      req_valid = '1;
      for (int i = 0; i < N; i++) req_bcd[2'(i)] = rand_bcd(1'b0);
      for (int i = 0; i < N; i++) serve($urandom_range(3, 0), 1'b0);
    end

    req_valid[0] = 1'b1;
    req_bcd[0]   = 40'h00_0000_1010;
    serve(2, 1'b0);
    chk("dec1010", 64'(rsp_binary), 64'h3F2);

    req_valid[1] = 1'b1;
    req_bcd[1]   = 40'h00_0000_001A;
    serve(0, 1'b0);

    req_valid[2] = 1'b1;
    req_bcd[2]   = 40'h42_9496_7295;
    serve(0, 1'b1);
    chk("max", 64'(rsp_binary), 64'hFFFF_FFFF);

    req_valid[1] = 1'b1;
    req_bcd[1]   = rand_bcd(1'b0);
    serve(1, 1'b0);

    // Reset in the middle of a conversion.
    req_valid[2] = 1'b1;
    req_bcd[2]   = rand_bcd(1'b0);
    #1;
    chk("rst_grant", 64'(req_ready), 64'b0100);
    @(negedge clk);
    req_valid[2] = 1'b0;
    chk("rst_start_seen", 64'(conv_start), 64'd1);
    @(negedge clk);
    @(negedge clk);
    req_valid[3] = 1'b1;
    req_valid[0] = 1'b1;
    req_bcd[3]   = rand_bcd(1'b0);
    req_bcd[0]   = rand_bcd(1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_ready", 64'(req_ready), 64'd0);
    chk("mid_rsp", 64'(rsp_valid), 64'd0);
    chk("mid_bin", 64'(rsp_binary), 64'd0);
    chk("mid_err", 64'(rsp_error), 64'd0);
    chk("mid_start", 64'(conv_start), 64'd0);
    chk("mid_bcd", 64'(conv_bcd), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    chk("post_rst_rsp", 64'(rsp_valid), 64'd0);
    serve(1, 1'b0);
    serve(0, 1'b0);

    // Random subsets, random delays, occasional bad digits.
    for (int it = 0; it < 30; it++) begin
      mask = N'($urandom_range(15, 1));
      req_valid = mask;
      for (int i = 0; i < N; i++)
        req_bcd[2'(i)] = rand_bcd($urandom_range(4, 0) == 0);
      guard = 0;
      while (req_valid != '0 && guard < 2 * N) begin
        serve($urandom_range(4, 0), 1'($urandom_range(1, 0)));
        guard++;
      end
      chk("drained", 64'(req_valid), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
